debounce_bank: RTL

//  Parametrised N-channel pushbutton debouncer for FPGA board inputs.
//  - Replaces the single-channel shift-register debouncer.
//  - Adds a 2-flop input synchroniser, a counter-based stability window, a reset value
//    and one-cycle rise/fall pulses per channel.
//  - Sits between raw board buttons/switches and the control FSMs; all outputs are synchronous to clk.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_bank_if.sv | 13 +
 rtl/debounce_chan.sv | 101 ++++++++++
 rtl/debounce_bank.sv | 32 +++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer bank.
package debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 16;
    localparam int unsigned HOLD_CYCLES_DEF   = 1000;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_ARMING = 1'b1
    } chan_state_e;

    // Never returns 0 so derived counter widths stay legal for tiny limits.
    function automatic int unsigned clog2_safe(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Button-side and clean-side signal bundle for debounce_bank.
interface debounce_bank_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] clean;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] hold;

    modport master (output button, input clean, input rise, input fall, input hold);
    modport slave  (input button, output clean, output rise, output fall, output hold);
endinterface

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, stability counter, edge pulses.
// Define LONG_PRESS_EN to add the per-channel long-press hold pulse.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic hold
);
    localparam int unsigned CNT_W = clog2_safe(STABLE_CYCLES + 1);

    logic             sync0_q, sync1_q;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    chan_state_e      state;

    // Arming is implied whenever the synchronised level disagrees with clean.
    assign state = (sync1_q != clean_q) ? ST_ARMING : ST_STABLE;

    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state)
            ST_STABLE: cnt_d = '0;
            ST_ARMING: begin
                if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    clean_d = sync1_q;
                    rise_d  = sync1_q;
                    fall_d  = ~sync1_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= RESET_VAL;
            sync1_q <= RESET_VAL;
            clean_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync0_q <= button;
            sync1_q <= sync0_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = clog2_safe(HOLD_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              hold_q;

    // Counter saturates, so the pulse fires once per press; a release re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else if (!clean_q) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            if (hold_cnt_q != HOLD_W'(HOLD_CYCLES)) begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
            hold_q <= (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
        end
    end

    assign hold = hold_q;
`else
    logic unused_hold_cfg;
    assign unused_hold_cfg = |HOLD_CYCLES;
    assign hold            = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N-channel pushbutton debouncer; each channel is an independent debounce_chan.
// Define LONG_PRESS_EN to enable the long-press hold pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter logic        RESET_VAL     = 1'b0,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    debounce_bank_if.slave  bus
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .RESET_VAL     (RESET_VAL)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .button (bus.button[i]),
            .clean  (bus.clean[i]),
            .rise   (bus.rise[i]),
            .fall   (bus.fall[i]),
            .hold   (bus.hold[i])
        );
    end

endmodule
